// File: rtl/mvm_noc_pkg.sv
// mvm_noc_pkg
//   Shared definitions for the MVM NoC weight-load path: TUSER field
//   offsets, the RF-write opcode, the load-controller state encoding and
//   default interface widths.
//   No ports (package).
package mvm_noc_pkg;

  // Default interface widths
  localparam int DATAW_DEFAULT  = 512;
  localparam int DESTW_DEFAULT  = 12;
  localparam int IDW_DEFAULT    = 32;
  localparam int USERW_DEFAULT  = 76;
  localparam int NUM_RF_DEFAULT = 64;
  localparam int ADDRW_DEFAULT  = 9;

  // TUSER layout: [8:0] RF word address, [10:9] opcode, [11+k] one-hot RF select
  localparam int ADDR_LSB   = 0;
  localparam int OP_LSB     = 9;
  localparam int RF_SEL_LSB = 11;

  localparam logic [1:0] OP_RF_WRITE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } rf_load_state_t;

endpackage

// File: rtl/mvm_rf_load_ctrl_axis_out_reg.sv
// axis_out_reg
//   One-entry AXIS register slice. The upstream side is ready whenever the
//   entry is empty or is being drained in the same cycle, so a full-rate
//   stream passes with no bubbles. Payload width is a parameter.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake
//   in_data  [W-1:0]      upstream payload
//   out_valid / out_ready downstream handshake
//   out_data [W-1:0]      registered payload, held stable while stalled
module axis_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_reg;
  logic [W-1:0] data_reg;

  assign in_ready  = !valid_reg || out_ready;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (in_ready) begin
      // Entry is free this cycle: either refill it or let it go empty.
      valid_reg <= in_valid;
      if (in_valid) begin
        data_reg <= in_data;
      end
    end
  end

endmodule

// File: rtl/mvm_rf_load_ctrl.sv
// mvm_rf_load_ctrl
//   Sequences weight loading into the MVM register files over the NoC.
//   One command names a destination node, an RF word address, a first RF
//   and an RF count; the block then pulls one weight word per RF from the
//   weight stream and emits one single-beat flit per RF, tagged with an
//   RF-write TUSER (address, opcode, one-hot RF select). RF index wraps
//   from NUM_RF-1 back to 0.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      load command handshake (ready only in IDLE)
//   cmd_dest, cmd_addr         NoC destination, RF word address
//   cmd_rf_base, cmd_num_rf    first RF index, RF count (0 = no-op, DONE only)
//   w_tvalid/w_tready/w_tdata  weight word stream
//   axis_m_*                   flit output (TID = 0, TLAST = TVALID)
//   busy                       command in progress
//   done                       one-cycle pulse after the last flit is taken
//   stall_cnt                  output stall cycles since last command
// Configuration
//   MVM_RF_LOAD_STATS_EN: when defined, stall_cnt counts cycles with
//   axis_m_tvalid && !axis_m_tready (saturating, cleared on command
//   accept); otherwise stall_cnt is tied to zero.
module mvm_rf_load_ctrl
  import mvm_noc_pkg::*;
#(
  parameter int DATAW  = DATAW_DEFAULT,
  parameter int DESTW  = DESTW_DEFAULT,
  parameter int IDW    = IDW_DEFAULT,
  parameter int USERW  = USERW_DEFAULT,
  parameter int NUM_RF = NUM_RF_DEFAULT,
  parameter int ADDRW  = ADDRW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [DESTW-1:0] cmd_dest,
  input  logic [ADDRW-1:0] cmd_addr,
  input  logic [5:0]       cmd_rf_base,
  input  logic [6:0]       cmd_num_rf,
  input  logic             w_tvalid,
  output logic             w_tready,
  input  logic [DATAW-1:0] w_tdata,
  output logic             axis_m_tvalid,
  input  logic             axis_m_tready,
  output logic [DATAW-1:0] axis_m_tdata,
  output logic [DESTW-1:0] axis_m_tdest,
  output logic [IDW-1:0]   axis_m_tid,
  output logic [USERW-1:0] axis_m_tuser,
  output logic             axis_m_tlast,
  output logic             busy,
  output logic             done,
  output logic [15:0]      stall_cnt
);

  localparam int PW = DESTW + USERW + DATAW;

  rf_load_state_t   state_reg;
  logic             cmd_ready_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [DESTW-1:0] dest_reg;
  logic [ADDRW-1:0] addr_reg;
  logic [5:0]       idx_reg;
  logic [6:0]       remain_reg;

  logic             out_free;
  logic             w_hs;
  logic [USERW-1:0] tuser_next;
  logic [PW-1:0]    slice_out;

  // Weight words are only taken while words remain and the slice can take one.
  assign w_tready = (state_reg == LOAD) && (remain_reg != 7'd0) && out_free;
  assign w_hs     = w_tvalid && w_tready;

  always_comb begin
    tuser_next = '0;
    tuser_next[ADDR_LSB +: ADDRW]    = addr_reg;
    tuser_next[OP_LSB +: 2]          = OP_RF_WRITE;
    tuser_next[RF_SEL_LSB +: NUM_RF] = {{(NUM_RF-1){1'b0}}, 1'b1} << idx_reg;
  end

  axis_out_reg #(
    .W (PW)
  ) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_hs),
    .in_ready  (out_free),
    .in_data   ({dest_reg, tuser_next, w_tdata}),
    .out_valid (axis_m_tvalid),
    .out_ready (axis_m_tready),
    .out_data  (slice_out)
  );

  assign axis_m_tdata = slice_out[DATAW-1:0];
  assign axis_m_tuser = slice_out[DATAW +: USERW];
  assign axis_m_tdest = slice_out[DATAW+USERW +: DESTW];
  assign axis_m_tid   = '0;
  assign axis_m_tlast = axis_m_tvalid;

  assign cmd_ready = cmd_ready_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cmd_ready_reg <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      dest_reg      <= '0;
      addr_reg      <= '0;
      idx_reg       <= '0;
      remain_reg    <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            dest_reg   <= cmd_dest;
            addr_reg   <= cmd_addr;
            idx_reg    <= cmd_rf_base;
            remain_reg <= cmd_num_rf;
            if (cmd_num_rf == 7'd0) begin
              // Empty command: acknowledge with DONE, never leave IDLE.
              done_reg <= 1'b1;
            end else begin
              state_reg     <= LOAD;
              cmd_ready_reg <= 1'b0;
              busy_reg      <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (w_hs) begin
            idx_reg    <= (idx_reg == 6'(NUM_RF - 1)) ? 6'd0 : idx_reg + 6'd1;
            remain_reg <= remain_reg - 7'd1;
          end
          // All words pulled and the slice drains (or is already empty).
          if ((remain_reg == 7'd0) && out_free) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg     <= IDLE;
          cmd_ready_reg <= 1'b1;
        end
        default: begin
          state_reg     <= IDLE;
          cmd_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

`ifdef MVM_RF_LOAD_STATS_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (cmd_valid && cmd_ready_reg) begin
      stall_cnt_reg <= '0;
    end else if (axis_m_tvalid && !axis_m_tready && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = '0;
`endif

endmodule
